// File: rtl/addsub_seq.sv
// Multi-cycle two's-complement adder/subtractor. Operands are processed CHUNK bits
// per cycle, LSB chunk first, with the inter-chunk carry held in a register.
module addsub_seq #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_r, b_r, acc_r, acc_n;
  logic             c_r;
  logic [CW-1:0]    cnt;
  logic [CHUNK:0]   csum;
  logic             last;
  int unsigned      base;

  logic [WIDTH-1:0] res_r;
  logic             carry_r, ovf_r, zero_r;

  // Narrow adder: one chunk of A plus the (possibly inverted) chunk of B plus carry-in.
  always_comb begin
    base  = CHUNK * cnt;
    csum  = {1'b0, a_r[base +: CHUNK]} + {1'b0, b_r[base +: CHUNK]} + {{CHUNK{1'b0}}, c_r};
    acc_n = acc_r;
    acc_n[base +: CHUNK] = csum[CHUNK-1:0];
    last  = (cnt == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid)  state_n = RUN;
      RUN:     if (last)      state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      acc_r   <= '0;
      c_r     <= 1'b0;
      cnt     <= '0;
      res_r   <= '0;
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
      zero_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r   <= a;
          b_r   <= sub ? ~b : b;
          c_r   <= sub;
          cnt   <= '0;
          acc_r <= '0;
        end
        RUN: begin
          acc_r <= acc_n;
          c_r   <= csum[CHUNK];
          if (last) begin
            // Visible outputs only change here so they hold until the next completion.
            cnt     <= '0;
            res_r   <= acc_n;
            carry_r <= csum[CHUNK];
            ovf_r   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (acc_n[WIDTH-1] != a_r[WIDTH-1]);
            zero_r  <= ~|acc_n;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign result    = res_r;
  assign carry     = carry_r;
  assign overflow  = ovf_r;
  assign zero      = zero_r;

endmodule
